ram64_filler: RTL
=================

# ram64_filler

Upstream write sequencer for the 64-word RAM. It drives the RAM's `in`/`address`/`load` inputs. On a `start` pulse it walks all 64 addresses and writes a constant or incrementing 16-bit pattern. When idle it passes host write/read requests straight through to the RAM. It sits between the host datapath and the RAM64 instance, and is used for power-up clear and pattern fill before memory tests.

## Interface
- `WIDTH`, default 16: data word width.
- `AW`, default 6: address width. Depth is 2^AW = 64.
- `clock`  in  1  single clock. All state updates occur on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a fill. Sampled on a rising edge in IDLE only.
- `mode`  in  1  0 = constant pattern, 1 = incrementing pattern. Latched with `start`.
- `seed`  in  WIDTH  pattern base value. Latched with `start`.
- `host_in`  in  WIDTH  host write data.
- `host_address`  in  AW  host address.
- `host_load`  in  1  host write enable.
- `ram_out`  in  WIDTH  RAM read data (combinational read of `ram_address`).
- `ram_in`  out  WIDTH  to RAM `in`.
- `ram_address`  out  AW  to RAM `address`.
- `ram_load`  out  1  to RAM `load`.
- `busy`  out  1  high in FILL and VERIFY.
- `done`  out  1  one-cycle pulse when a sequence completes.
- `error`  out  1  sticky verify mismatch flag. Constant 0 without verify.

## Operation
- States:
  - IDLE: RAM ports are a combinational mux of the host ports.
  - FILL: write sequence.
  - VERIFY: readback check, compiled in only.
  - DONE: one cycle.
- IDLE -> FILL on a rising edge with `start`=1. On that edge:
  - latch `mode`/`seed`;
  - clear counter `cnt` to 0;
  - clear `error`.
- FILL, each cycle:
  - `ram_address`=`cnt`, `ram_load`=1;
  - `ram_in`=`seed` in mode 0, or `seed`+`cnt` in mode 1. The sum is zero-extended to WIDTH and wraps modulo 2^WIDTH.
  - `cnt` increments on each edge.
- Leaving FILL when `cnt`=63 at the edge:
  - to VERIFY with `cnt` cleared to 0, if verify is compiled in;
  - otherwise to DONE.
- VERIFY, each cycle:
  - `ram_load`=0, `ram_address`=`cnt`;
  - on each edge, `ram_out` is compared to the expected pattern for `cnt`, and any mismatch sets `error`;
  - after `cnt`=63, go to DONE.
- DONE: `done`=1, RAM ports return to the host mux, next state is IDLE.
- While busy, host ports are ignored. `host_load` is never forwarded, so host writes are dropped and no host write is queued.
- `start` while busy or in DONE is ignored.
- `error` holds until the next accepted `start` or reset.

## Timing
- Reset (asynchronous, `reset_n`=0):
  - state=IDLE, `cnt`=0, latched `mode`/`seed`=0;
  - `busy`=0, `done`=0, `error`=0;
  - `ram_*` immediately equal `host_*`.
- `busy` is decoded from the state register. It rises in the cycle after the `start` edge.
- `busy` stays high for exactly 64 cycles (FILL only) or 128 cycles (FILL + VERIFY).
- `done` is high for exactly one cycle, immediately after the last FILL/VERIFY cycle. `busy` is 0 in that cycle.
- The RAM write for address k happens on the edge ending FILL cycle k. The first write lands one edge after `busy` rises.
- Reset asserted mid-FILL or mid-VERIFY:
  - abort immediately, with no `done` pulse;
  - addresses already written keep the fill value, and the rest are unchanged;
  - `error` is cleared.
- `start` held high continuously restarts a new fill on the first IDLE edge after DONE. Back-to-back fills are separated by exactly one IDLE cycle.

## Configuration
- `RAM64_FILLER_VERIFY_EN` defined:
  - the VERIFY state, comparator and `error` register are present;
  - a full sequence is 128 busy cycles.
- Macro undefined:
  - FILL goes directly to DONE;
  - `error` is tied to 0 and `ram_out` is unused;
  - a full sequence is 64 busy cycles.

## Test plan
- Reset: hold `reset_n`=0 with `host_load`=1, `host_address`=5, `host_in`=9 -> `busy`=`done`=`error`=0, and `ram_load`=1, `ram_address`=5, `ram_in`=9 combinationally.
- Constant fill: `start`=1 for one cycle, `mode`=0, `seed`=15 -> `busy` high 64 cycles (128 with verify) and one `done` pulse. Host reads of addresses 0, 16, 63 all return 15.
- Incrementing wrap: `mode`=1, `seed`=16'hFFF0 -> host reads return address 0=FFF0, 15=FFFF, 16=0000, 63=002F.
- Busy isolation: during FILL, pulse `start` and apply `host_load`=1, `host_address`=5, `host_in`=777 -> no restart, a single `done`, and address 5 reads the fill value.
- Reset abort: `seed`=3, mode 0, over prior contents 0; assert `reset_n`=0 when `cnt`=32 -> state IDLE, no `done`. Addresses 0–31 read 3, addresses 32–63 read 0.
- Verify (macro defined): testbench forces `ram_out` to a wrong value at VERIFY address 7 -> `error`=1 from the next edge through `done`. A new `start` clears it, and a clean run leaves `error`=0.

Source files
------------

// File: rtl/ram64_filler_if.sv
// ram64_filler_if: RAM-side port bundle of the 64-word RAM.
//   din     : write data to the RAM
//   address : RAM address; the read port follows it combinationally
//   load    : write enable, sampled by the RAM on the rising clock edge
//   dout    : RAM read data for the current address
// The sequencer uses the master modport. The RAM, or a RAM model, uses the
// slave modport.
interface ram64_filler_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 6
);
  logic [WIDTH-1:0] din;
  logic [AW-1:0]    address;
  logic             load;
  logic [WIDTH-1:0] dout;

  modport master (output din, output address, output load, input dout);
  modport slave  (input din, input address, input load, output dout);
endinterface

// File: rtl/ram64_filler.sv
// ram64_filler: write sequencer that sits in front of the 64-word RAM.
// When it is idle, the host write/read port passes straight through to the RAM.
// A start pulse fills all 2^AW addresses with a pattern. The pattern is either
// the constant seed, or seed + address, which wraps modulo 2^WIDTH.
//
// Optional feature: define RAM64_FILLER_VERIFY_EN to add a readback VERIFY pass
// and a sticky error flag. When the macro is undefined, error is tied to 0.
//
// Ports:
//   clock, reset_n        : single clock, asynchronous active-low reset
//   start, mode, seed     : fill request; mode and seed are latched with start
//   host_in/address/load  : host write data, address and write enable
//   ram (master)          : din/address/load to the RAM, dout read back
//   busy                  : high in FILL and VERIFY
//   done                  : one-cycle pulse at the end of a sequence
//   error                 : sticky readback mismatch flag
module ram64_filler #(
  parameter int WIDTH = 16,
  parameter int AW    = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] host_in,
  input  logic [AW-1:0]    host_address,
  input  logic             host_load,
  ram64_filler_if.master   ram,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [1:0] {IDLE, FILL, VERIFY, DONE} state_t;

  localparam logic [AW-1:0] CNT_LAST = '1;

  state_t           state, state_next;
  logic [AW-1:0]    cnt, cnt_next;
  logic             mode_q;
  logic [WIDTH-1:0] seed_q;
  logic [WIDTH-1:0] pattern;
  logic             accept;

  // A start request is honoured only in IDLE. While the sequencer is busy,
  // or in DONE, start is ignored.
  assign accept = (state == IDLE) && start;

  // This is the expected word for the current address. FILL writes it, and
  // VERIFY compares against it.
  assign pattern = mode_q ? seed_q + WIDTH'(cnt) : seed_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_q <= 1'b0;
      seed_q <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        mode_q <= mode;
        seed_q <= seed;
      end
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement leaves a value held and no latch is inferred.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    ram.din     = host_in;
    ram.address = host_address;
    ram.load    = host_load;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = FILL;
          cnt_next   = '0;
        end
      end
      FILL: begin
        ram.din     = pattern;
        ram.address = cnt;
        ram.load    = 1'b1;
        // The counter wraps from the last address to 0, which is the start
        // address that VERIFY needs.
        cnt_next    = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
`ifdef RAM64_FILLER_VERIFY_EN
          state_next = VERIFY;
`else
          state_next = DONE;
`endif
        end
      end
      VERIFY: begin
        ram.din     = pattern;
        ram.address = cnt;
        ram.load    = 1'b0;
        cnt_next    = cnt + 1'b1;
        if (cnt == CNT_LAST) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state == FILL) || (state == VERIFY);
  assign done = (state == DONE);

`ifdef RAM64_FILLER_VERIFY_EN
  logic error_q;

  // The error flag is sticky through DONE and IDLE. Only an accepted start or
  // reset clears it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      error_q <= 1'b0;
    end else if (accept) begin
      error_q <= 1'b0;
    end else if ((state == VERIFY) && (ram.dout != pattern)) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  // Without the verify pass, the read data is not observed.
  logic unused_dout;
  assign unused_dout = ^ram.dout;
  assign error       = 1'b0;
`endif

endmodule
